mxv_frame_parser: RTL and testbench

- Front-end stage of the MxV datapath. Consumes the byte stream from the UART receiver and decodes framed commands.
- Sets the matrix order N and routes matrix and vector bytes into the row FIFOs and the vector FIFO.
- Generates the Prep_Valid / Data_Valid / Stop pulse sequence that drives push_Ctl directly downstream.
- Malformed frames are discarded; a clear pulse flushes any partially written FIFO data.

---
 rtl/mxv_pkg.sv | 25 ++
 rtl/mxv_fifo_router.sv | 59 +++++
 rtl/mxv_frame_parser.sv | 127 ++++++++++++
 tb/tb_mxv_frame_parser.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mxv_pkg.sv
// Shared types and constants for the MxV frame parser and its FIFO router.
// Holds the parser state encoding, framing bytes, command codes and size limits.
package mxv_pkg;

    localparam logic [7:0] HDR      = 8'hFE;
    localparam logic [7:0] TRL      = 8'hEF;
    localparam logic [7:0] CMD_SIZE = 8'h01;
    localparam logic [7:0] CMD_DATA = 8'h03;
    localparam logic [7:0] MAX_N    = 8'd8;
    localparam logic [3:0] VEC_SEL  = 4'd8;

    typedef enum logic [2:0] {
        HUNT,
        LEN,
        CMD,
        PAYLOAD,
        END
    } state_e;

    // LEN of a data frame: CMD byte + N*N matrix bytes + N vector bytes, mod 256.
    function automatic logic [7:0] data_len(input logic [7:0] n);
        return 8'd1 + n * n + n;
    endfunction

endpackage

// File: rtl/mxv_fifo_router.sv
// Steers data-command payload bytes to row FIFOs (k mod N) then the vector FIFO.
// One-cycle registered write strobe per advance; no backpressure, the stream is never stalled.
module mxv_fifo_router
    import mxv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       advance_i,
    input  logic [7:0] n_i,
    input  logic [7:0] data_i,
    output logic       last_o,
    output logic [7:0] fifo_data_o,
    output logic       fifo_push_o,
    output logic [3:0] fifo_sel_o
);

    logic [7:0] k_q;
    logic [3:0] row_q;
    logic [7:0] nn;
    logic [7:0] data_q;
    logic       push_q;
    logic [3:0] sel_q;

    assign nn     = n_i * n_i;
    assign last_o = (k_q == nn + n_i - 8'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_q    <= '0;
            row_q  <= '0;
            data_q <= '0;
            push_q <= 1'b0;
            sel_q  <= '0;
        end else begin
            push_q <= 1'b0;
            if (clear_i) begin
                k_q   <= '0;
                row_q <= '0;
            end else if (advance_i) begin
                push_q <= 1'b1;
                data_q <= data_i;
                k_q    <= k_q + 8'd1;
                // Matrix arrives column-major, so consecutive bytes walk the rows.
                if (k_q < nn) begin
                    sel_q <= row_q;
                    row_q <= (row_q == n_i[3:0] - 4'd1) ? 4'd0 : row_q + 4'd1;
                end else begin
                    sel_q <= VEC_SEL;
                end
            end
        end
    end

    assign fifo_data_o = data_q;
    assign fifo_push_o = push_q;
    assign fifo_sel_o  = sel_q;

endmodule

// File: rtl/mxv_frame_parser.sv
// Decodes HDR/LEN/CMD/payload/TRL frames from the UART byte stream into N, push_Ctl pulses and FIFO writes.
// All outputs registered, visible the cycle after the byte; no backpressure, one byte per cycle accepted.
module mxv_frame_parser
    import mxv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] N,
    output logic       Prep_Valid,
    output logic       Data_Valid,
    output logic       Stop,
    output logic [7:0] fifo_data,
    output logic       fifo_push,
    output logic [3:0] fifo_sel,
    output logic       fifo_clear,
    output logic       frame_err
);

    state_e     state_q;
    logic [7:0] len_q;
    logic [7:0] n_q;
    logic       is_data_q;
    logic       dv_seen_q;
    logic       prep_q, dv_q, stop_q, err_q, clr_q;

    logic size_ok, data_cmd_ok, size_val_ok, bad;
    logic rt_clear, rt_adv, rt_last;

    assign size_ok     = (rx_data == CMD_SIZE) && (len_q == 8'd2);
    assign data_cmd_ok = (rx_data == CMD_DATA) && (n_q != 8'd0) && (len_q == data_len(n_q));
    assign size_val_ok = (rx_data != 8'd0) && (rx_data <= MAX_N);

    always_comb begin
        bad = 1'b0;
        case (state_q)
            CMD:     bad = !(size_ok || data_cmd_ok);
            PAYLOAD: bad = !is_data_q && !size_val_ok;
            END:     bad = (rx_data != TRL);
            default: bad = 1'b0;
        endcase
    end

    assign rt_clear = rx_valid && (state_q == CMD) && data_cmd_ok;
    assign rt_adv   = rx_valid && (state_q == PAYLOAD) && is_data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= HUNT;
            len_q     <= '0;
            n_q       <= '0;
            is_data_q <= 1'b0;
            dv_seen_q <= 1'b0;
            prep_q    <= 1'b0;
            dv_q      <= 1'b0;
            stop_q    <= 1'b0;
            err_q     <= 1'b0;
            clr_q     <= 1'b0;
        end else begin
            prep_q <= 1'b0;
            dv_q   <= 1'b0;
            stop_q <= 1'b0;
            err_q  <= 1'b0;
            clr_q  <= 1'b0;
            if (rx_valid) begin
                if (bad) begin
                    // The offending byte is consumed here, so it can never restart a frame.
                    err_q     <= 1'b1;
                    clr_q     <= dv_seen_q;
                    dv_seen_q <= 1'b0;
                    state_q   <= HUNT;
                end else begin
                    case (state_q)
                        HUNT: if (rx_data == HDR) state_q <= LEN;
                        LEN: begin
                            len_q   <= rx_data;
                            state_q <= CMD;
                        end
                        CMD: begin
                            is_data_q <= data_cmd_ok;
                            dv_q      <= data_cmd_ok;
                            dv_seen_q <= data_cmd_ok;
                            state_q   <= PAYLOAD;
                        end
                        PAYLOAD: begin
                            if (!is_data_q) begin
                                n_q     <= rx_data;
                                prep_q  <= 1'b1;
                                state_q <= END;
                            end else if (rt_last) begin
                                state_q <= END;
                            end
                        end
                        END: begin
                            stop_q    <= 1'b1;
                            dv_seen_q <= 1'b0;
                            state_q   <= HUNT;
                        end
                        default: state_q <= HUNT;
                    endcase
                end
            end
        end
    end

    mxv_fifo_router u_router (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (rt_clear),
        .advance_i   (rt_adv),
        .n_i         (n_q),
        .data_i      (rx_data),
        .last_o      (rt_last),
        .fifo_data_o (fifo_data),
        .fifo_push_o (fifo_push),
        .fifo_sel_o  (fifo_sel)
    );

    assign N          = n_q;
    assign Prep_Valid = prep_q;
    assign Data_Valid = dv_q;
    assign Stop       = stop_q;
    assign fifo_clear = clr_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_mxv_frame_parser.sv
// Frame-level randomized bench: each generated frame carries its own expected per-byte outputs.
module tb_mxv_frame_parser;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] N;
    logic       Prep_Valid, Data_Valid, Stop;
    logic [7:0] fifo_data;
    logic       fifo_push;
    logic [3:0] fifo_sel;
    logic       fifo_clear, frame_err;

    mxv_frame_parser dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .N          (N),
        .Prep_Valid (Prep_Valid),
        .Data_Valid (Data_Valid),
        .Stop       (Stop),
        .fifo_data  (fifo_data),
        .fifo_push  (fifo_push),
        .fifo_sel   (fifo_sel),
        .fifo_clear (fifo_clear),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         prep, dv, stop, err, clr, push;
        logic [3:0] sel;
        logic [7:0] dat;
    } exp_t;

    int checks   = 0;
    int failures = 0;
    int model_n  = 0;
    bit gaps     = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t quiet();
        exp_t e;
        e = '{default: 0};
        return e;
    endfunction

    task automatic step(input bit v, input logic [7:0] d, input exp_t e, input string tag);
        @(negedge clk);
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        #1;
        check_eq({tag, ":pulses"},
                 {26'd0, Prep_Valid, Data_Valid, Stop, frame_err, fifo_clear, fifo_push},
                 {26'd0, e.prep, e.dv, e.stop, e.err, e.clr, e.push});
        check_eq({tag, ":N"}, 32'(N), 32'(model_n));
        if (e.push) begin
            check_eq({tag, ":sel"}, 32'(fifo_sel), 32'(e.sel));
            check_eq({tag, ":dat"}, 32'(fifo_data), 32'(e.dat));
        end
    endtask

    task automatic send(input logic [7:0] d, input exp_t e, input string tag);
        step(1'b1, d, e, tag);
        if (gaps && $urandom_range(0, 3) == 0)
            step(1'b0, 8'($urandom), quiet(), "idle");
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        rx_valid = 1'b0;
        #1;
        model_n = 0;
        check_eq("reset_outs",
                 {6'd0, N, Prep_Valid, Data_Valid, Stop, fifo_data, fifo_push, fifo_sel, fifo_clear, frame_err},
                 32'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [7:0] bad_trailer();
        logic [7:0] t;
        t = 8'($urandom);
        if (t == 8'hEF) t = 8'h55;
        return t;
    endfunction

    task automatic size_frame(input logic [7:0] val, input bit good_trl);
        exp_t e;
        send(8'hFE, quiet(), "sz_hdr");
        send(8'h02, quiet(), "sz_len");
        send(8'h01, quiet(), "sz_cmd");
        e = quiet();
        if (val >= 8'd1 && val <= 8'd8) begin
            model_n = int'(val);
            e.prep  = 1'b1;
            send(val, e, "sz_val");
            e = quiet();
            if (good_trl) begin
                e.stop = 1'b1;
                send(8'hEF, e, "sz_trl");
            end else begin
                e.err = 1'b1;
                send(bad_trailer(), e, "sz_badtrl");
            end
        end else begin
            e.err = 1'b1;
            send(val, e, "sz_badval");
            send(8'hEF, quiet(), "sz_drop");
        end
    endtask

    // mode: 0 good, 1 bad trailer, 2 bad LEN, 3 reset after third payload byte
    task automatic data_frame(input int mode, input bit fixed);
        exp_t       e;
        logic [7:0] len, d;
        logic [7:0] fixed_pl [6];
        int         nn, tot;
        fixed_pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB};
        nn  = model_n * model_n;
        tot = nn + model_n;
        len = 8'(1 + tot);
        if (model_n == 0 || mode == 2) begin
            if (model_n == 0) len = 8'($urandom);
            else              len = len + 8'($urandom_range(1, 6));
            send(8'hFE, quiet(), "dt_hdr");
            send(len, quiet(), "dt_len");
            e = quiet();
            e.err = 1'b1;
            send(8'h03, e, "dt_badcmd");
            return;
        end
        send(8'hFE, quiet(), "dt_hdr");
        send(len, quiet(), "dt_len");
        e = quiet();
        e.dv = 1'b1;
        send(8'h03, e, "dt_cmd");
        for (int k = 0; k < tot; k++) begin
            d = (fixed && k < 6) ? fixed_pl[k] : 8'($urandom);
            e = quiet();
            e.push = 1'b1;
            e.dat  = d;
            e.sel  = (k < nn) ? 4'(k % model_n) : 4'd8;
            send(d, e, "dt_pl");
            if (mode == 3 && k == 2) begin
                do_reset();
                return;
            end
        end
        e = quiet();
        if (mode == 1) begin
            e.err = 1'b1;
            e.clr = 1'b1;
            send(bad_trailer(), e, "dt_badtrl");
        end else begin
            e.stop = 1'b1;
            send(8'hEF, e, "dt_trl");
        end
    endtask

    task automatic bad_cmd_frame();
        exp_t       e;
        logic [7:0] c;
        c = 8'($urandom);
        if (c == 8'h01 || c == 8'h03) c = 8'h02;
        send(8'hFE, quiet(), "bc_hdr");
        send(8'h02, quiet(), "bc_len");
        e = quiet();
        e.err = 1'b1;
        send(c, e, "bc_cmd");
    endtask

    task automatic size_badlen_frame();
        exp_t e;
        send(8'hFE, quiet(), "sl_hdr");
        send(8'h03, quiet(), "sl_len");
        e = quiet();
        e.err = 1'b1;
        send(8'h01, e, "sl_cmd");
    endtask

    task automatic garbage();
        logic [7:0] g;
        for (int i = 0; i < int'($urandom_range(1, 4)); i++) begin
            g = 8'($urandom);
            if (g == 8'hFE) g = 8'h00;
            send(g, quiet(), "junk");
        end
    endtask

    initial begin
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        do_reset();

        size_frame(8'd3, 1'b1);
        size_frame(8'd2, 1'b1);
        data_frame(0, 1'b1);
        size_frame(8'd9, 1'b1);
        size_frame(8'd0, 1'b1);
        data_frame(1, 1'b0);
        data_frame(2, 1'b0);
        step(1'b0, 8'hFE, quiet(), "idle_hdr");
        do_reset();
        data_frame(0, 1'b0);
        size_frame(8'd2, 1'b1);
        data_frame(3, 1'b0);
        size_frame(8'd5, 1'b1);
        size_frame(8'd4, 1'b0);
        data_frame(0, 1'b0);
        size_frame(8'd8, 1'b1);
        data_frame(0, 1'b0);
        size_frame(8'd1, 1'b1);
        data_frame(1, 1'b0);

        gaps = 1'b1;
        for (int f = 0; f < 80; f++) begin
            case ($urandom_range(0, 7))
                0: size_frame(8'($urandom_range(0, 10)), $urandom_range(0, 4) != 0);
                1, 2: data_frame(0, 1'b0);
                3: data_frame(1, 1'b0);
                4: data_frame(2, 1'b0);
                5: bad_cmd_frame();
                6: size_badlen_frame();
                default: garbage();
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
